vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator with a pixel-clock enable, selectable sync polarity and a configurable pipeline delay. The delay keeps sync, blank and RGB aligned with the latency of an upstream pixel renderer. It sits between the game renderer, which consumes `x`/`y` and produces RGB, and the DAC/VGA pins. It generalises the fixed 640x480 controller to any mode and to renderers with multi-cycle latency.

---
 rtl/vga_timing_pkg.sv | 57 +++++
 rtl/vga_delay_line.sv | 41 ++++
 rtl/vga_timing_gen.sv | 139 +++++++++++++
 tb/tb_vga_timing_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing definitions: standard mode constants, the control
// bundle that travels through the pipeline delay, and a total-span helper.
package vga_timing_pkg;

  // Sum of the four segments of a line or a frame.
  function automatic int span_total(input int sync_w, input int back_w,
                                    input int active_w, input int front_w);
    return sync_w + back_w + active_w + front_w;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock, negative syncs.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FRONT  = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BACK   = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FRONT  = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BACK   = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;
  localparam int VGA640_H_TOTAL  = span_total(VGA640_H_SYNC, VGA640_H_BACK,
                                              VGA640_H_ACTIVE, VGA640_H_FRONT);
  localparam int VGA640_V_TOTAL  = span_total(VGA640_V_SYNC, VGA640_V_BACK,
                                              VGA640_V_ACTIVE, VGA640_V_FRONT);
  localparam int VGA640_H_START  = VGA640_H_SYNC + VGA640_H_BACK;
  localparam int VGA640_V_START  = VGA640_V_SYNC + VGA640_V_BACK;

  // 800x600@60, 40 MHz pixel clock, positive syncs; needs an 11-bit counter.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FRONT  = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BACK   = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FRONT  = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BACK   = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;
  localparam int SVGA800_H_TOTAL  = span_total(SVGA800_H_SYNC, SVGA800_H_BACK,
                                               SVGA800_H_ACTIVE, SVGA800_H_FRONT);
  localparam int SVGA800_V_TOTAL  = span_total(SVGA800_V_SYNC, SVGA800_V_BACK,
                                               SVGA800_V_ACTIVE, SVGA800_V_FRONT);
  localparam int SVGA800_H_START  = SVGA800_H_SYNC + SVGA800_H_BACK;
  localparam int SVGA800_V_START  = SVGA800_V_SYNC + SVGA800_V_BACK;

  // Undelayed control bundle; hs/vs are logical "sync asserted" flags,
  // polarity is applied only at the output register.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{hs: 1'b0, vs: 1'b0, act: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to match the renderer latency.
// DEPTH=0 degenerates to a plain wire.
module vga_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 0,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      // Clock, reset and enable have no role in a zero-length delay.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, en};
      assign dout        = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // Shift one stage per pixel tick; reset clears every stage.
      // NOTE: this array is a handful of flops carrying control, not a RAM, so
      // every entry is reset; leaving it unreset would emit garbage syncs for
      // the first DEPTH ticks after reset.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else if (en) begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Counters and undelayed decode
// feed the renderer; sync/blank are delayed by PIPE_DLY ticks so that they
// line up with the renderer's colour at the output register.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = VGA640_H_ACTIVE,
  parameter int   H_FRONT  = VGA640_H_FRONT,
  parameter int   H_SYNC   = VGA640_H_SYNC,
  parameter int   H_BACK   = VGA640_H_BACK,
  parameter int   V_ACTIVE = VGA640_V_ACTIVE,
  parameter int   V_FRONT  = VGA640_V_FRONT,
  parameter int   V_SYNC   = VGA640_V_SYNC,
  parameter int   V_BACK   = VGA640_V_BACK,
  parameter logic HS_POL   = VGA640_HS_POL,
  parameter logic VS_POL   = VGA640_VS_POL,
  parameter int   COLOR_W  = 10,
  parameter int   PIPE_DLY = 0,
  parameter int   CNT_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_en,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [CNT_W-1:0]   h_count,
  output logic [CNT_W-1:0]   v_count,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               in_active,
  output logic               line_start,
  output logic               frame_start,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               video_on,
  output logic [COLOR_W-1:0] r_out,
  output logic [COLOR_W-1:0] g_out,
  output logic [COLOR_W-1:0] b_out
);

  localparam int H_TOTAL = span_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam int V_TOTAL = span_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  // Segment boundaries in counter width; order is sync, back, active, front.
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

  logic  h_act;
  logic  v_act;
  ctrl_t ctrl_raw;
  ctrl_t ctrl_d;

  // Raster counters: h wraps at end of line and carries into v.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count <= '0;
      v_count <= '0;
    end else if (pix_en) begin
      if (h_count == H_LAST) begin
        h_count <= '0;
        v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
      end else begin
        h_count <= h_count + 1'b1;
      end
    end
  end

  // Undelayed decode of the current counter position.
  // NOTE: every output of this block is assigned on every path (defaults
  // first), so no latch can be inferred if a branch is added later.
  always_comb begin
    h_act       = 1'b0;
    v_act       = 1'b0;
    in_active   = 1'b0;
    x           = '0;
    y           = '0;
    ctrl_raw    = CTRL_IDLE;
    line_start  = 1'b0;
    frame_start = 1'b0;

    h_act     = (h_count >= H_ACT_START) && (h_count < H_ACT_END);
    v_act     = (v_count >= V_ACT_START) && (v_count < V_ACT_END);
    in_active = h_act && v_act;
    if (in_active) begin
      x = h_count - H_ACT_START;
      y = v_count - V_ACT_START;
    end

    ctrl_raw.hs  = (h_count < H_SYNC_END);
    ctrl_raw.vs  = (v_count < V_SYNC_END);
    ctrl_raw.act = in_active;

    // Gated by rst_n so no start pulse escapes while reset is held.
    line_start  = rst_n && pix_en && (h_count == '0);
    frame_start = line_start && (v_count == '0);
  end

  // Align sync and blank with the renderer's colour latency.
  vga_delay_line #(
    .WIDTH  ($bits(ctrl_t)),
    .DEPTH  (PIPE_DLY),
    .RST_VAL(CTRL_IDLE)
  ) u_ctrl_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pix_en),
    .din  (ctrl_raw),
    .dout (ctrl_d)
  );

  // Output register: apply sync polarity and blank the colour outside active.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_hs   <= ~HS_POL;
      vga_vs   <= ~VS_POL;
      video_on <= 1'b0;
      r_out    <= '0;
      g_out    <= '0;
      b_out    <= '0;
    end else if (pix_en) begin
      vga_hs   <= ctrl_d.hs ? HS_POL : ~HS_POL;
      vga_vs   <= ctrl_d.vs ? VS_POL : ~VS_POL;
      video_on <= ctrl_d.act;
      r_out    <= ctrl_d.act ? r_in : '0;
      g_out    <= ctrl_d.act ? g_in : '0;
      b_out    <= ctrl_d.act ? b_in : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen. Two instances share stimulus: one with
// a 3-tick delay and positive hsync, one pass-through with positive vsync.
// The reference computes every expectation from the pixel-tick count since
// reset release, using modulo arithmetic over a small test mode.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 3, HSY = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VSY = 2, VB = 3;
  localparam int HT = HSY + HB + HA + HF;   // 28
  localparam int VT = VSY + VB + VA + VF;   // 13
  localparam int FRAME = HT * VT;           // 364
  localparam int CW = 10;
  localparam int NW = 10;

  localparam int   DLY_A = 3, DLY_B = 0;
  localparam logic HP_A  = 1'b1, VP_A = 1'b0;
  localparam logic HP_B  = 1'b0, VP_B = 1'b1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  logic [CW-1:0] r_in = '0, g_in = '0, b_in = '0;

  logic [NW-1:0] h_a, v_a, x_a, y_a, h_b, v_b, x_b, y_b;
  logic act_a, ls_a, fs_a, hs_a, vs_a, von_a;
  logic act_b, ls_b, fs_b, hs_b, vs_b, von_b;
  logic [CW-1:0] r_a, g_a, b_a, r_b, g_b, b_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(HP_A), .VS_POL(VP_A), .COLOR_W(CW), .PIPE_DLY(DLY_A), .CNT_W(NW)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .h_count(h_a), .v_count(v_a), .x(x_a), .y(y_a),
    .in_active(act_a), .line_start(ls_a), .frame_start(fs_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .video_on(von_a),
    .r_out(r_a), .g_out(g_a), .b_out(b_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
    .HS_POL(HP_B), .VS_POL(VP_B), .COLOR_W(CW), .PIPE_DLY(DLY_B), .CNT_W(NW)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .h_count(h_b), .v_count(v_b), .x(x_b), .y(y_b),
    .in_active(act_b), .line_start(ls_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .video_on(von_b),
    .r_out(r_b), .g_out(g_b), .b_out(b_b)
  );

  typedef struct packed {
    logic [NW-1:0]        h, v, x, y;
    logic                 act, ls, fs;
    logic [1:0]           hs, vs, von;
    logic [1:0][CW-1:0]   r, g, b;
  } exp_t;

  exp_t sb[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference state: ticks since reset release plus the registered outputs.
  int   n;
  int   dly [2];
  logic hpol [2];
  logic vpol [2];
  logic [1:0]         m_hs, m_vs, m_von;
  logic [1:0][CW-1:0] m_r, m_g, m_b;

  function automatic int h_of(input int t);
    return (t % FRAME) % HT;
  endfunction

  function automatic int v_of(input int t);
    return (t % FRAME) / HT;
  endfunction

  function automatic bit is_active(input int t);
    return (h_of(t) >= HSY + HB) && (h_of(t) < HSY + HB + HA) &&
           (v_of(t) >= VSY + VB) && (v_of(t) < VSY + VB + VA);
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      if (miscompares <= 20)
        $display("FAIL %s: got %0h expected %0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 2; i++) begin
      m_hs[i]  = ~hpol[i];
      m_vs[i]  = ~vpol[i];
      m_von[i] = 1'b0;
      m_r[i]   = '0;
      m_g[i]   = '0;
      m_b[i]   = '0;
    end
  endtask

  // Apply one clock of stimulus, push the outputs expected for this cycle,
  // then advance the reference across the coming edge.
  task automatic drive(input logic pe, input logic rn,
                       input logic [CW-1:0] r, input logic [CW-1:0] g,
                       input logic [CW-1:0] b);
    exp_t e;
    int   q;
    bit   a, hsa, vsa;
    @(posedge clk);
    #1;
    pix_en = pe;
    rst_n  = rn;
    r_in   = r;
    g_in   = g;
    b_in   = b;

    e.h   = NW'(h_of(n));
    e.v   = NW'(v_of(n));
    e.act = is_active(n);
    e.x   = e.act ? NW'(h_of(n) - (HSY + HB)) : '0;
    e.y   = e.act ? NW'(v_of(n) - (VSY + VB)) : '0;
    e.ls  = rn && pe && (h_of(n) == 0);
    e.fs  = e.ls && (v_of(n) == 0);
    e.hs  = m_hs;
    e.vs  = m_vs;
    e.von = m_von;
    e.r   = m_r;
    e.g   = m_g;
    e.b   = m_b;
    sb.push_back(e);

    if (!rn) begin
      model_reset();
    end else if (pe) begin
      for (int i = 0; i < 2; i++) begin
        q   = n - dly[i];
        a   = (q >= 0) && is_active(q);
        hsa = (q >= 0) && (h_of(q) < HSY);
        vsa = (q >= 0) && (v_of(q) < VSY);
        m_hs[i]  = hsa ? hpol[i] : ~hpol[i];
        m_vs[i]  = vsa ? vpol[i] : ~vpol[i];
        m_von[i] = a;
        m_r[i]   = a ? r : '0;
        m_g[i]   = a ? g : '0;
        m_b[i]   = a ? b : '0;
      end
      n++;
    end
  endtask

  // Monitor: one expectation per clock, compared half a cycle after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("h_count_a", 32'(h_a), 32'(e.h));
        check("v_count_a", 32'(v_a), 32'(e.v));
        check("x_a", 32'(x_a), 32'(e.x));
        check("y_a", 32'(y_a), 32'(e.y));
        check("in_active_a", 32'(act_a), 32'(e.act));
        check("line_start_a", 32'(ls_a), 32'(e.ls));
        check("frame_start_a", 32'(fs_a), 32'(e.fs));
        check("h_count_b", 32'(h_b), 32'(e.h));
        check("v_count_b", 32'(v_b), 32'(e.v));
        check("x_b", 32'(x_b), 32'(e.x));
        check("y_b", 32'(y_b), 32'(e.y));
        check("in_active_b", 32'(act_b), 32'(e.act));
        check("line_start_b", 32'(ls_b), 32'(e.ls));
        check("frame_start_b", 32'(fs_b), 32'(e.fs));
        check("vga_hs_a", 32'(hs_a), 32'(e.hs[0]));
        check("vga_vs_a", 32'(vs_a), 32'(e.vs[0]));
        check("video_on_a", 32'(von_a), 32'(e.von[0]));
        check("r_out_a", 32'(r_a), 32'(e.r[0]));
        check("g_out_a", 32'(g_a), 32'(e.g[0]));
        check("b_out_a", 32'(b_a), 32'(e.b[0]));
        check("vga_hs_b", 32'(hs_b), 32'(e.hs[1]));
        check("vga_vs_b", 32'(vs_b), 32'(e.vs[1]));
        check("video_on_b", 32'(von_b), 32'(e.von[1]));
        check("r_out_b", 32'(r_b), 32'(e.r[1]));
        check("g_out_b", 32'(g_b), 32'(e.g[1]));
        check("b_out_b", 32'(b_b), 32'(e.b[1]));
      end
    end
  end

  // Stimulus.
  initial begin
    logic [CW-1:0] rr, gg, bb;
    int            rst_hold;
    bit            reached;

    dly[0] = DLY_A;  hpol[0] = HP_A;  vpol[0] = VP_A;
    dly[1] = DLY_B;  hpol[1] = HP_B;  vpol[1] = VP_B;
    model_reset();
    repeat (3) @(posedge clk);

    // Reset still held, then a full frame at full rate with saturated colour.
    drive(1'b1, 1'b0, '1, '1, '1);
    for (int i = 0; i < FRAME + 40; i++) drive(1'b1, 1'b1, '1, '1, '1);

    // Pixel tick on every second clock with random colour.
    for (int i = 0; i < 2 * FRAME + 20; i++) begin
      rr = CW'($urandom); gg = CW'($urandom); bb = CW'($urandom);
      drive(logic'(i % 2), 1'b1, rr, gg, bb);
    end

    // Run to a mid-frame active position, then hold reset for 3 clocks.
    reached = 1'b0;
    for (int k = 0; k < 2 * FRAME && !reached; k++) begin
      if (h_of(n) == 12 && v_of(n) == 7) reached = 1'b1;
      else drive(1'b1, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));
    end
    check("reach_reset_point", 32'(reached), 32'd1);
    for (int i = 0; i < 3; i++)
      drive(logic'($urandom % 2), 1'b0, CW'($urandom), CW'($urandom), CW'($urandom));
    for (int i = 0; i < 5; i++)
      drive(1'b1, 1'b1, CW'($urandom), CW'($urandom), CW'($urandom));

    // Random tick rate with occasional short resets.
    rst_hold = 0;
    for (int i = 0; i < 1600; i++) begin
      if (rst_hold == 0 && ($urandom % 400) == 0) rst_hold = 1 + int'($urandom % 3);
      rr = CW'($urandom); gg = CW'($urandom); bb = CW'($urandom);
      drive(logic'(($urandom % 4) != 0), logic'(rst_hold == 0), rr, gg, bb);
      if (rst_hold > 0) rst_hold--;
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
